// File: rtl/pipeline_reg_if.sv
// Handshake bundle for the elastic pipeline register: upstream
// valid/ready/data, downstream valid/ready/data, flush and occupancy.
interface pipeline_reg_if #(
  parameter int N     = 64,
  parameter int DEPTH = 1
) ();
  logic [N-1:0]               in_data;
  logic                       in_valid;
  logic                       in_ready;
  logic [N-1:0]               out_data;
  logic                       out_valid;
  logic                       out_ready;
  logic                       flush;
  logic [$clog2(DEPTH+1)-1:0] count;

  // Environment side: drives offers, downstream ready and flush.
  modport master (
    output in_data, in_valid, out_ready, flush,
    input  in_ready, out_data, out_valid, count
  );

  // Register side.
  modport slave (
    input  in_data, in_valid, out_ready, flush,
    output in_ready, out_data, out_valid, count
  );
endinterface

// File: rtl/pipeline_reg.sv
// Elastic DEPTH-stage pipeline register with per-stage valid bits,
// valid/ready backpressure, bubble collapsing and synchronous flush.
// Stage 0 is the input side, stage DEPTH-1 drives the outputs.
module pipeline_reg #(
  parameter int           N         = 64,
  parameter int           DEPTH     = 1,
  parameter logic [N-1:0] RESET_VAL = {N{1'b0}}
) (
  input logic          clk,
  input logic          reset,
  pipeline_reg_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);

  // Number of set bits in a valid vector.
  function automatic logic [CW-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [CW-1:0] c;
    c = {CW{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  logic [N-1:0]     data_r [DEPTH];
  logic [DEPTH-1:0] v_r;
  logic [CW-1:0]    count_r;

  logic [DEPTH-1:0] go_s;
  logic [DEPTH-1:0] load_s;
  logic [DEPTH-1:0] leave_s;
  logic [DEPTH-1:0] v_nxt_s;
  logic             in_ready_s;

  // Stage k may take new contents when out_ready is high or any stage
  // from k to the tail is empty (the unrolled go/adv chain); this is what
  // lets gaps close while the output is stalled.
  always_comb begin
    logic g;
    for (int k = 0; k < DEPTH; k++) begin
      g = bus.out_ready;
      for (int j = k; j < DEPTH; j++) begin
        g = g | ~v_r[j];
      end
      go_s[k] = g;
    end
  end

  assign in_ready_s = go_s[0] & ~bus.flush;

  // Per-stage load/leave decode and next valid vector; flush empties every
  // stage and suppresses all loads so data registers hold.
  always_comb begin
    load_s    = {DEPTH{1'b0}};
    leave_s   = {DEPTH{1'b0}};
    v_nxt_s   = v_r;
    load_s[0] = bus.in_valid & in_ready_s;
    for (int k = 1; k < DEPTH; k++) begin
      load_s[k] = v_r[k-1] & go_s[k] & ~bus.flush;
    end
    for (int k = 0; k < DEPTH - 1; k++) begin
      leave_s[k] = v_r[k] & load_s[k+1];
    end
    leave_s[DEPTH-1] = v_r[DEPTH-1] & bus.out_ready;
    for (int k = 0; k < DEPTH; k++) begin
      if (bus.flush) begin
        v_nxt_s[k] = 1'b0;
      end else if (load_s[k]) begin
        v_nxt_s[k] = 1'b1;
      end else if (leave_s[k]) begin
        v_nxt_s[k] = 1'b0;
      end else begin
        v_nxt_s[k] = v_r[k];
      end
    end
  end

  // Stage registers: valid bits and occupancy move together; data only
  // changes on a load so bubbles never toggle the data flops.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < DEPTH; k++) begin
        data_r[k] <= RESET_VAL;
      end
      v_r     <= {DEPTH{1'b0}};
      count_r <= {CW{1'b0}};
    end else begin
      v_r     <= v_nxt_s;
      count_r <= popcount(v_nxt_s);
      if (load_s[0]) begin
        data_r[0] <= bus.in_data;
      end
      for (int k = 1; k < DEPTH; k++) begin
        if (load_s[k]) begin
          data_r[k] <= data_r[k-1];
        end
      end
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_data  = data_r[DEPTH-1];
  assign bus.out_valid = v_r[DEPTH-1];
  assign bus.count     = count_r;

endmodule

// File: tb/tb_pipeline_reg.sv
// Directed bench for pipeline_reg: a DEPTH=3 and a DEPTH=2 instance,
// inputs driven and outputs sampled on the falling clock edge.
module tb_pipeline_reg;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  pipeline_reg_if #(.N(64), .DEPTH(3)) b3 ();
  pipeline_reg_if #(.N(64), .DEPTH(2)) b2 ();

  pipeline_reg #(.N(64), .DEPTH(3), .RESET_VAL(64'h0)) u_dut3 (
    .clk(clk), .reset(reset), .bus(b3)
  );
  pipeline_reg #(.N(64), .DEPTH(2), .RESET_VAL(64'h0)) u_dut2 (
    .clk(clk), .reset(reset), .bus(b2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk3(input string tag, input logic ov, input logic [63:0] od, input int cnt);
    check({tag, ".valid"}, 64'(b3.out_valid), 64'(ov));
    if (ov) check({tag, ".data"}, b3.out_data, od);
    check({tag, ".count"}, 64'(b3.count), 64'(cnt));
  endtask

  task automatic chk2(input string tag, input logic ov, input logic [63:0] od, input int cnt);
    check({tag, ".valid"}, 64'(b2.out_valid), 64'(ov));
    if (ov) check({tag, ".data"}, b2.out_data, od);
    check({tag, ".count"}, 64'(b2.count), 64'(cnt));
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset with random offers on both instances
    reset        = 1'b0;
    b3.in_valid  = 1'b1;
    b3.in_data   = {$urandom, $urandom};
    b3.out_ready = 1'b1;
    b3.flush     = 1'b0;
    b2.in_valid  = 1'b1;
    b2.in_data   = {$urandom, $urandom};
    b2.out_ready = 1'b1;
    b2.flush     = 1'b0;
    #3;
    check("rst.valid", 64'(b3.out_valid), 64'h0);
    check("rst.data",  b3.out_data, 64'h0);
    check("rst.count", 64'(b3.count), 64'h0);
    check("rst.ready", 64'(b3.in_ready), 64'h1);
    tick(); tick();
    check("rst2.valid", 64'(b3.out_valid), 64'h0);
    check("rst2.data",  b3.out_data, 64'h0);
    check("rst2.ready", 64'(b3.in_ready), 64'h1);
    check("rst2.d2cnt", 64'(b2.count), 64'h0);
    reset       = 1'b1;
    b3.in_valid = 1'b0;
    b2.in_valid = 1'b0;
    b2.out_ready = 1'b0;
    tick();
    chk3("rel", 1'b0, 64'h0, 0);
    check("rel.data",  b3.out_data, 64'h0);
    check("rel.ready", 64'(b3.in_ready), 64'h1);

    // Streaming, out_ready=1
    b3.out_ready = 1'b1;
    b3.in_valid = 1'b1; b3.in_data = 64'h1; tick(); chk3("str1", 1'b0, 64'h0, 1);
    b3.in_data = 64'h2; tick(); chk3("str2", 1'b0, 64'h0, 2);
    b3.in_data = 64'h3; tick(); chk3("str3", 1'b1, 64'h1, 3);
    b3.in_data = 64'h4; tick(); chk3("str4", 1'b1, 64'h2, 3);
    b3.in_valid = 1'b0; tick(); chk3("str5", 1'b1, 64'h3, 2);
    tick(); chk3("str6", 1'b1, 64'h4, 1);
    tick(); chk3("str7", 1'b0, 64'h0, 0);

    // Stall with a bubble that collapses
    b3.out_ready = 1'b0;
    b3.in_valid = 1'b1; b3.in_data = 64'hA; tick(); chk3("stl1", 1'b0, 64'h0, 1);
    b3.in_valid = 1'b0; tick(); chk3("stl2", 1'b0, 64'h0, 1);
    b3.in_valid = 1'b1; b3.in_data = 64'hB; tick(); chk3("stl3", 1'b1, 64'hA, 2);
    b3.in_data = 64'hC;
    #1 check("stl3.ready", 64'(b3.in_ready), 64'h1);
    tick(); chk3("stl4", 1'b1, 64'hA, 3);
    b3.in_data = 64'hD;
    #1 check("stl4.ready", 64'(b3.in_ready), 64'h0);
    tick(); chk3("stl5", 1'b1, 64'hA, 3);
    b3.in_valid = 1'b0; b3.out_ready = 1'b1;
    tick(); chk3("drn1", 1'b1, 64'hB, 2);
    tick(); chk3("drn2", 1'b1, 64'hC, 1);
    tick(); chk3("drn3", 1'b0, 64'h0, 0);

    // DEPTH=2 full pipe: simultaneous accept and emit
    b2.in_valid = 1'b1; b2.in_data = 64'h10; tick(); chk2("fp1", 1'b0, 64'h0, 1);
    b2.in_data = 64'h11; tick(); chk2("fp2", 1'b1, 64'h10, 2);
    b2.in_data = 64'h12;
    #1 check("fp2.ready", 64'(b2.in_ready), 64'h0);
    b2.out_ready = 1'b1;
    #1 check("fp3.ready", 64'(b2.in_ready), 64'h1);
    check("fp3.emit", b2.out_data, 64'h10);
    tick(); chk2("fp3", 1'b1, 64'h11, 2);
    b2.in_valid = 1'b0; tick(); chk2("fp4", 1'b1, 64'h12, 1);
    tick(); chk2("fp5", 1'b0, 64'h0, 0);

    // Flush a full DEPTH=3 pipe
    b3.out_ready = 1'b0;
    b3.in_valid = 1'b1; b3.in_data = 64'h21; tick();
    b3.in_data = 64'h22; tick();
    b3.in_data = 64'h23; tick(); chk3("fl.full", 1'b1, 64'h21, 3);
    b3.in_data = 64'hFF; b3.flush = 1'b1; b3.out_ready = 1'b1;
    #1 check("fl.ready", 64'(b3.in_ready), 64'h0);
    tick();
    chk3("fl1", 1'b0, 64'h0, 0);
    check("fl1.hold", b3.out_data, 64'h21);
    b3.flush = 1'b0; b3.in_valid = 1'b0;
    #1 check("fl1.ready", 64'(b3.in_ready), 64'h1);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("fl.noff", 64'(b3.out_valid), 64'h0);
      check("fl.data", b3.out_data, 64'h21);
    end

    // Asynchronous reset mid-stream at count=2
    b3.out_ready = 1'b0;
    b3.in_valid = 1'b1; b3.in_data = 64'h31; tick();
    b3.in_data = 64'h32; tick(); chk3("ar.pre", 1'b0, 64'h0, 2);
    b3.in_valid = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk3("ar.now", 1'b0, 64'h0, 0);
    check("ar.data",  b3.out_data, 64'h0);
    check("ar.ready", 64'(b3.in_ready), 64'h1);
    tick();
    reset = 1'b1;
    tick();
    chk3("ar.post", 1'b0, 64'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
